camera_stream_packetizer: RTL and testbench

Upstream stage of `dm_blurring_filter`: converts the raw camera pixel stream (frame-start pulse plus qualified 12-bit RGB444 pixels) into a ready/valid packet stream with start-of-packet and end-of-packet markers. Packet length is always exactly IMG_WIDTH×IMG_LENGTH. A small FIFO absorbs downstream back-pressure. Short frames and overflows are padded so the filter's line buffers never lose alignment.

---
 rtl/camera_stream_packetizer.sv | 222 ++++++++++++++++++++++
 tb/tb_camera_stream_packetizer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_stream_packetizer.sv
// rtl/camera_stream_packetizer.sv - camera pixel stream to fixed-length sop/eop packet stream
//
// Converts a frame-start pulse plus qualified camera pixels into a ready/valid
// packet stream of exactly IMG_WIDTH*IMG_LENGTH pixels per packet. A show-ahead
// FIFO absorbs downstream back-pressure. Short frames and overflows are padded
// with PAD_VALUE so every packet keeps its full length.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   cam_frame_start     one-cycle pulse, next frame begins
//   cam_pixel_valid     cam_pixel qualified this cycle (camera cannot be stalled)
//   cam_pixel           camera pixel
//   ready_in            downstream accepts this cycle
//   valid_out           FIFO head is valid
//   startofpacket_out   head is pixel 0 of a packet
//   endofpacket_out     head is the last pixel of a packet
//   data_out            head pixel
//   fifo_level          current FIFO occupancy
//   frame_error         sticky short-frame / overflow flag
//   frames_sent         number of eop transfers, wrapping

module camera_stream_packetizer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_LENGTH = 240,
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cam_frame_start,
  input  logic                          cam_pixel_valid,
  input  logic [DATA_WIDTH-1:0]         cam_pixel,
  input  logic                          ready_in,
  output logic                          valid_out,
  output logic                          startofpacket_out,
  output logic                          endofpacket_out,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_error,
  output logic [15:0]                   frames_sent
);

  localparam int N  = IMG_WIDTH * IMG_LENGTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_PAD    = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t state, state_next;
  logic [CW-1:0] pix_cnt, pix_cnt_next;

  // FIFO storage and pointers; the extra pointer MSB separates full from empty
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic          full;
  logic          rd_en;
  logic          no_room;

  // write-side decisions produced by the FSM output process
  logic                  wr_en;
  logic [CW-1:0]         wr_idx;
  logic [DATA_WIDTH-1:0] wr_pix;
  logic [EW-1:0]         wr_data;
  logic                  err_set;

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == FULL_LVL);
  assign valid_out  = (fifo_level != '0);
  assign rd_en      = valid_out && ready_in;
  // a write into a full FIFO is only safe when the head leaves on the same edge
  assign no_room    = full && !rd_en;

  assign head              = mem[rd_ptr[AW-1:0]];
  assign startofpacket_out = valid_out && head[EW-1];
  assign endofpacket_out   = valid_out && head[EW-2];
  assign data_out          = valid_out ? head[DATA_WIDTH-1:0] : '0;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pix_cnt <= '0;
    end else begin
      state   <= state_next;
      pix_cnt <= pix_cnt_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next   = state;
    pix_cnt_next = pix_cnt;
    case (state)
      S_IDLE, S_WAIT: begin
        if (cam_frame_start) begin
          state_next   = S_ACTIVE;
          pix_cnt_next = '0;
          if (cam_pixel_valid) begin
            // pixel 0 arrives with the frame start
            if (no_room) begin
              state_next = S_PAD;
            end else if (N == 1) begin
              state_next = S_WAIT;
            end else begin
              pix_cnt_next = CW'(1);
            end
          end
        end
      end
      S_ACTIVE: begin
        if (cam_frame_start && (pix_cnt != '0)) begin
          state_next = S_PAD;
        end else if (cam_pixel_valid) begin
          if (no_room) begin
            // pad resumes at the index of the dropped pixel
            state_next = S_PAD;
          end else if (pix_cnt == LAST_IDX) begin
            state_next   = S_WAIT;
            pix_cnt_next = '0;
          end else begin
            pix_cnt_next = pix_cnt + CW'(1);
          end
        end
      end
      S_PAD: begin
        if (!full) begin
          if (pix_cnt == LAST_IDX) begin
            state_next   = S_WAIT;
            pix_cnt_next = '0;
          end else begin
            pix_cnt_next = pix_cnt + CW'(1);
          end
        end
      end
      default: begin
        state_next   = S_IDLE;
        pix_cnt_next = '0;
      end
    endcase
  end

  // FSM outputs: FIFO write request, entry contents, error flag set
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = pix_cnt;
    wr_pix  = PAD_VALUE;
    err_set = 1'b0;
    case (state)
      S_IDLE, S_WAIT: begin
        wr_idx = '0;
        if (cam_frame_start && cam_pixel_valid) begin
          if (no_room) begin
            err_set = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_pix = cam_pixel;
          end
        end
      end
      S_ACTIVE: begin
        if (cam_frame_start && (pix_cnt != '0)) begin
          err_set = 1'b1;
        end else if (cam_pixel_valid) begin
          if (no_room) begin
            err_set = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_pix = cam_pixel;
          end
        end
      end
      S_PAD: begin
        wr_en = !full;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
    wr_data = {(wr_idx == '0), (wr_idx == LAST_IDX), wr_pix};
  end

  // FIFO storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // FIFO pointers, sticky error flag and frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      frame_error <= 1'b0;
      frames_sent <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (err_set) begin
        frame_error <= 1'b1;
      end
      if (rd_en && head[EW-2]) begin
        frames_sent <= frames_sent + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_camera_stream_packetizer.sv
// tb/tb_camera_stream_packetizer.sv - self-checking bench for camera_stream_packetizer

module tb_camera_stream_packetizer;

  localparam int W  = 4;
  localparam int L  = 3;
  localparam int N  = W * L;
  localparam int DW = 12;
  localparam int FD = 4;
  localparam logic [DW-1:0] PADV = 12'h000;

  logic          clk = 1'b0;
  logic          reset;
  logic          cam_frame_start;
  logic          cam_pixel_valid;
  logic [DW-1:0] cam_pixel;
  logic          ready_in;
  logic          valid_out;
  logic          startofpacket_out;
  logic          endofpacket_out;
  logic [DW-1:0] data_out;
  logic [2:0]    fifo_level;
  logic          frame_error;
  logic [15:0]   frames_sent;

  int cmp = 0;
  int err = 0;
  int peak = 0;

  logic [DW+1:0] got[$];
  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] px_q[$];

  camera_stream_packetizer #(
    .IMG_WIDTH(W), .IMG_LENGTH(L), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .PAD_VALUE(PADV)
  ) dut (
    .clk(clk), .reset(reset),
    .cam_frame_start(cam_frame_start), .cam_pixel_valid(cam_pixel_valid),
    .cam_pixel(cam_pixel), .ready_in(ready_in),
    .valid_out(valid_out), .startofpacket_out(startofpacket_out),
    .endofpacket_out(endofpacket_out), .data_out(data_out),
    .fifo_level(fifo_level), .frame_error(frame_error), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  // capture each transfer half a cycle before the edge that performs it
  always @(negedge clk) begin
    if (!reset && valid_out && ready_in)
      got.push_back({startofpacket_out, endofpacket_out, data_out});
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
  end

  // reference packet: first n_real entries of px_q, then pad to N; sop at 0, eop at N-1
  function automatic void model_frame(input int n_real);
    for (int i = 0; i < N; i++)
      exp_q.push_back({(i == 0), (i == N - 1), (i < n_real) ? px_q[i] : PADV});
  endfunction

  function automatic void rand_pixels(input int n);
    px_q.delete();
    for (int i = 0; i < n; i++) px_q.push_back(DW'($urandom));
  endfunction

  task automatic step(input logic fs, input logic pv, input logic [DW-1:0] px);
    cam_frame_start = fs;
    cam_pixel_valid = pv;
    cam_pixel       = px;
    @(posedge clk);
    #1;
    cam_frame_start = 1'b0;
    cam_pixel_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  // bounded wait for n transfers, then a quiet tail so extra transfers show up
  task automatic wait_got(input int n);
    for (int i = 0; i < 300 && got.size() < n; i++) idle(1);
    idle(12);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    cmp++; if (valid_out !== 1'b0) begin err++; $display("FAIL reset_valid got %b expected 0", valid_out); end
    cmp++; if (startofpacket_out !== 1'b0) begin err++; $display("FAIL reset_sop got %b expected 0", startofpacket_out); end
    cmp++; if (endofpacket_out !== 1'b0) begin err++; $display("FAIL reset_eop got %b expected 0", endofpacket_out); end
    cmp++; if (data_out !== '0) begin err++; $display("FAIL reset_data got %h expected 000", data_out); end
    cmp++; if (fifo_level !== '0) begin err++; $display("FAIL reset_level got %0d expected 0", fifo_level); end
    cmp++; if (frame_error !== 1'b0) begin err++; $display("FAIL reset_error got %b expected 0", frame_error); end
    cmp++; if (frames_sent !== 16'd0) begin err++; $display("FAIL reset_frames got %0d expected 0", frames_sent); end
  endtask

  task automatic test_basic();
    got.delete(); exp_q.delete(); px_q.delete();
    for (int i = 1; i <= N; i++) px_q.push_back(DW'(i));
    model_frame(N);
    ready_in = 1'b1;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, px_q[i]);
    wait_got(exp_q.size());
    cmp++; if (got.size() !== exp_q.size()) begin err++; $display("FAIL basic_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      cmp++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL basic_entry%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
    cmp++; if (frames_sent !== 16'd1) begin err++; $display("FAIL basic_frames got %0d expected 1", frames_sent); end
    cmp++; if (frame_error !== 1'b0) begin err++; $display("FAIL basic_error got %b expected 0", frame_error); end
  endtask

  task automatic test_backpressure();
    int sent;
    got.delete(); exp_q.delete();
    rand_pixels(N);
    model_frame(N);
    peak = 0;
    sent = 0;
    ready_in = 1'b1;
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < 40; c++) begin
      ready_in = !(c >= 3 && c <= 8);
      if (c % 2 == 0 && sent < N) begin
        step(1'b0, 1'b1, px_q[sent]);
        sent++;
      end else begin
        step(1'b0, 1'b0, '0);
      end
    end
    ready_in = 1'b1;
    wait_got(exp_q.size());
    cmp++; if (got.size() !== exp_q.size()) begin err++; $display("FAIL bp_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      cmp++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL bp_entry%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
    cmp++; if (peak > FD || peak < 2) begin err++; $display("FAIL bp_peak got %0d expected 2..%0d", peak, FD); end
    cmp++; if (frame_error !== 1'b0) begin err++; $display("FAIL bp_error got %b expected 0", frame_error); end
    cmp++; if (frames_sent !== 16'd2) begin err++; $display("FAIL bp_frames got %0d expected 2", frames_sent); end
  endtask

  task automatic test_short_frame();
    got.delete(); exp_q.delete();
    rand_pixels(N);
    model_frame(5);
    ready_in = 1'b1;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, px_q[i]);
    // premature frame start with a pixel that must be dropped
    step(1'b1, 1'b1, DW'($urandom));
    cmp++; if (frame_error !== 1'b1) begin err++; $display("FAIL short_error got %b expected 1", frame_error); end
    // the lost frame: a start during padding and its pixels are all ignored
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, DW'($urandom));
    wait_got(exp_q.size());
    cmp++; if (got.size() !== exp_q.size()) begin err++; $display("FAIL short_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      cmp++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL short_entry%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
    cmp++; if (frames_sent !== 16'd3) begin err++; $display("FAIL short_frames got %0d expected 3", frames_sent); end
    // a later frame start recovers with a full frame
    got.delete(); exp_q.delete();
    rand_pixels(N);
    model_frame(N);
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, px_q[i]);
    wait_got(exp_q.size());
    cmp++; if (got.size() !== exp_q.size()) begin err++; $display("FAIL recover_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      cmp++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL recover_entry%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
    cmp++; if (frame_error !== 1'b1) begin err++; $display("FAIL short_sticky got %b expected 1", frame_error); end
  endtask

  task automatic test_extra_pixels();
    pulse_reset();
    got.delete(); exp_q.delete();
    rand_pixels(N + 2);
    model_frame(N);
    ready_in = 1'b1;
    // pixel 0 shares the cycle with the frame start
    step(1'b1, 1'b1, px_q[0]);
    for (int i = 1; i < N + 2; i++) begin
      idle($urandom_range(0, 2));
      step(1'b0, 1'b1, px_q[i]);
    end
    wait_got(exp_q.size());
    cmp++; if (got.size() !== exp_q.size()) begin err++; $display("FAIL extra_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      cmp++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL extra_entry%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
    cmp++; if (frame_error !== 1'b0) begin err++; $display("FAIL extra_error got %b expected 0", frame_error); end
    cmp++; if (frames_sent !== 16'd1) begin err++; $display("FAIL extra_frames got %0d expected 1", frames_sent); end
  endtask

  task automatic test_overflow();
    pulse_reset();
    got.delete(); exp_q.delete();
    rand_pixels(6);
    model_frame(FD);
    ready_in = 1'b0;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, px_q[i]);
    cmp++; if (fifo_level !== 3'(FD)) begin err++; $display("FAIL ovf_level got %0d expected %0d", fifo_level, FD); end
    cmp++; if (frame_error !== 1'b1) begin err++; $display("FAIL ovf_error got %b expected 1", frame_error); end
    idle(5);
    ready_in = 1'b1;
    wait_got(exp_q.size());
    cmp++; if (got.size() !== exp_q.size()) begin err++; $display("FAIL ovf_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      cmp++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL ovf_entry%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
    cmp++; if (frames_sent !== 16'd1) begin err++; $display("FAIL ovf_frames got %0d expected 1", frames_sent); end
  endtask

  task automatic test_reset_mid_frame();
    pulse_reset();
    got.delete(); exp_q.delete();
    rand_pixels(3);
    ready_in = 1'b0;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, px_q[i]);
    cmp++; if (fifo_level !== 3'd3) begin err++; $display("FAIL mid_level_pre got %0d expected 3", fifo_level); end
    reset = 1'b1;
    idle(1);
    cmp++; if ({valid_out, startofpacket_out, endofpacket_out} !== 3'b000) begin err++; $display("FAIL mid_flags got %b expected 000", {valid_out, startofpacket_out, endofpacket_out}); end
    cmp++; if (data_out !== '0) begin err++; $display("FAIL mid_data got %h expected 000", data_out); end
    cmp++; if (fifo_level !== '0) begin err++; $display("FAIL mid_level got %0d expected 0", fifo_level); end
    reset = 1'b0;
    ready_in = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, DW'($urandom));
    idle(4);
    cmp++; if (got.size() !== 0) begin err++; $display("FAIL mid_silent got %0d transfers expected 0", got.size()); end
    rand_pixels(N);
    model_frame(N);
    step(1'b1, 1'b1, px_q[0]);
    for (int i = 1; i < N; i++) step(1'b0, 1'b1, px_q[i]);
    wait_got(exp_q.size());
    cmp++; if (got.size() !== exp_q.size()) begin err++; $display("FAIL mid_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      cmp++; if (got[i] !== exp_q[i]) begin err++; $display("FAIL mid_entry%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    reset           = 1'b1;
    cam_frame_start = 1'b0;
    cam_pixel_valid = 1'b0;
    cam_pixel       = '0;
    ready_in        = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_short_frame();
    test_extra_pixels();
    test_overflow();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
